// File: rtl/rom_port_arbiter.sv
// Shares one toggle-handshake SDRAM port between a ROM download writer and
// two CPU read ports. Each CPU port keeps a one-word cache so that repeated
// byte reads within the same 16-bit word are served without an SDRAM access.
module rom_port_arbiter #(
    parameter logic [22:0] CPU2_BASE = 23'h002000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_downl,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        cpu1_rd,
    input  logic [13:0] cpu1_addr,
    output logic [7:0]  cpu1_data,
    output logic        cpu1_ready,
    input  logic        cpu2_rd,
    input  logic [13:0] cpu2_addr,
    output logic [7:0]  cpu2_data,
    output logic        cpu2_ready,
    output logic        sd_req,
    input  logic        sd_ack,
    output logic [22:0] sd_a,
    output logic [1:0]  sd_ds,
    output logic        sd_we,
    output logic [15:0] sd_d,
    input  logic [15:0] sd_q,
    output logic        wr_overflow
);

    typedef enum logic [1:0] {IDLE, WRITE, READ1, READ2} state_t;

    state_t      state_reg;
    logic        sd_req_reg;
    logic [22:0] sd_a_reg;
    logic [1:0]  sd_ds_reg;
    logic        sd_we_reg;
    logic [15:0] sd_d_reg;
    logic        prefer2_reg;     // 1: CPU2 wins the next tie
    logic        discard_reg;     // read in flight must not be delivered
    logic [13:0] req_addr_reg;    // byte address of the read in flight

    logic        wr_prev_reg;
    logic        downl_prev_reg;
    logic        wbuf_valid_reg;
    logic [23:0] wbuf_addr_reg;
    logic [7:0]  wbuf_data_reg;
    logic        wr_overflow_reg;

    // Bit 24 of the download address lies outside the SDRAM word space.
    logic        unused_addr_msb;
    assign unused_addr_msb = ioctl_addr[24];

    logic        wr_edge, downl_rise, can_issue, done, read_done;
    logic        issue_wr, issue_rd1, issue_rd2;
    logic [1:0]  rd, hit, pend, ready;
    logic [13:0] addr [2];
    logic [7:0]  data [2];

    assign rd      = {cpu2_rd, cpu1_rd};
    assign addr[0] = cpu1_addr;
    assign addr[1] = cpu2_addr;

    assign wr_edge    = ioctl_downl && ioctl_wr && !wr_prev_reg;
    assign downl_rise = ioctl_downl && !downl_prev_reg;
    // A new transaction may only start once the SDRAM side has caught up,
    // which also covers an acknowledge still pending from before a reset.
    assign can_issue  = (state_reg == IDLE) && (sd_ack == sd_req_reg);
    assign done       = (state_reg != IDLE) && (sd_ack == sd_req_reg);
    assign read_done  = done && !discard_reg && !ioctl_downl;
    assign issue_wr   = can_issue && wbuf_valid_reg;
    assign issue_rd1  = can_issue && !wbuf_valid_reg && pend[0] && (!pend[1] || !prefer2_reg);
    assign issue_rd2  = can_issue && !wbuf_valid_reg && pend[1] && (!pend[0] || prefer2_reg);

    // Transaction FSM: one outstanding SDRAM access, request fields held until done.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            sd_req_reg   <= 1'b0;
            sd_a_reg     <= '0;
            sd_ds_reg    <= '0;
            sd_we_reg    <= 1'b0;
            sd_d_reg     <= '0;
            prefer2_reg  <= 1'b0;
            discard_reg  <= 1'b0;
            req_addr_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (issue_wr) begin
                        sd_req_reg <= ~sd_req_reg;
                        sd_a_reg   <= wbuf_addr_reg[23:1];
                        sd_ds_reg  <= {wbuf_addr_reg[0], ~wbuf_addr_reg[0]};
                        sd_d_reg   <= {wbuf_data_reg, wbuf_data_reg};
                        sd_we_reg  <= 1'b1;
                        state_reg  <= WRITE;
                    end else if (issue_rd1) begin
                        sd_req_reg   <= ~sd_req_reg;
                        sd_a_reg     <= {9'd0, cpu1_addr[13:1]};
                        sd_ds_reg    <= 2'b11;
                        sd_we_reg    <= 1'b0;
                        req_addr_reg <= cpu1_addr;
                        prefer2_reg  <= 1'b1;
                        discard_reg  <= 1'b0;
                        state_reg    <= READ1;
                    end else if (issue_rd2) begin
                        sd_req_reg   <= ~sd_req_reg;
                        sd_a_reg     <= {9'd0, cpu2_addr[13:1]} + CPU2_BASE;
                        sd_ds_reg    <= 2'b11;
                        sd_we_reg    <= 1'b0;
                        req_addr_reg <= cpu2_addr;
                        prefer2_reg  <= 1'b0;
                        discard_reg  <= 1'b0;
                        state_reg    <= READ2;
                    end
                end
                default: begin
                    if (downl_rise) discard_reg <= 1'b1;
                    if (done) state_reg <= IDLE;
                end
            endcase
        end
    end

    // Download edge detection and the one-entry write buffer.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_prev_reg     <= 1'b0;
            downl_prev_reg  <= 1'b0;
            wbuf_valid_reg  <= 1'b0;
            wbuf_addr_reg   <= '0;
            wbuf_data_reg   <= '0;
            wr_overflow_reg <= 1'b0;
        end else begin
            wr_prev_reg    <= ioctl_wr;
            downl_prev_reg <= ioctl_downl;
            if (wr_edge && (!wbuf_valid_reg || issue_wr)) begin
                wbuf_valid_reg <= 1'b1;
                wbuf_addr_reg  <= ioctl_addr[23:0];
                wbuf_data_reg  <= ioctl_dout;
            end else if (issue_wr) begin
                wbuf_valid_reg <= 1'b0;
            end
            if (wr_edge && wbuf_valid_reg && !issue_wr) wr_overflow_reg <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cpu
            localparam state_t MY_READ = (gi == 0) ? READ1 : READ2;
            logic        cache_valid_reg;
            logic [12:0] cache_addr_reg;
            logic [15:0] cache_word_reg;
            logic        served_reg;
            logic [13:0] served_addr_reg;
            logic        ready_reg;
            logic [7:0]  data_reg;
            logic        fresh;
            logic        my_done;

            // A held request is answered once; a new address or a low rd re-arms it.
            assign fresh    = !served_reg || (addr[gi] != served_addr_reg);
            assign hit[gi]  = rd[gi] && fresh && !ioctl_downl && cache_valid_reg
                              && (cache_addr_reg == addr[gi][13:1]);
            assign pend[gi] = rd[gi] && fresh && !ioctl_downl && !hit[gi];
            assign my_done  = read_done && (state_reg == MY_READ);
            assign ready[gi] = ready_reg;
            assign data[gi]  = data_reg;

            // Per-port cache fill, hit service and the one-cycle ready pulse.
            always_ff @(posedge clk_sys or posedge reset) begin
                if (reset) begin
                    cache_valid_reg <= 1'b0;
                    cache_addr_reg  <= '0;
                    cache_word_reg  <= '0;
                    served_reg      <= 1'b0;
                    served_addr_reg <= '0;
                    ready_reg       <= 1'b0;
                    data_reg        <= '0;
                end else begin
                    ready_reg <= 1'b0;
                    if (downl_rise) cache_valid_reg <= 1'b0;
                    if (my_done) begin
                        cache_valid_reg <= 1'b1;
                        cache_addr_reg  <= req_addr_reg[13:1];
                        cache_word_reg  <= sd_q;
                        data_reg        <= req_addr_reg[0] ? sd_q[15:8] : sd_q[7:0];
                        ready_reg       <= 1'b1;
                        served_reg      <= 1'b1;
                        served_addr_reg <= req_addr_reg;
                    end else if (hit[gi]) begin
                        data_reg        <= addr[gi][0] ? cache_word_reg[15:8] : cache_word_reg[7:0];
                        ready_reg       <= 1'b1;
                        served_reg      <= 1'b1;
                        served_addr_reg <= addr[gi];
                    end else if (!rd[gi] || (addr[gi] != served_addr_reg)) begin
                        served_reg <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    assign cpu1_ready  = ready[0];
    assign cpu2_ready  = ready[1];
    assign cpu1_data   = data[0];
    assign cpu2_data   = data[1];
    assign sd_req      = sd_req_reg;
    assign sd_a        = sd_a_reg;
    assign sd_ds       = sd_ds_reg;
    assign sd_we       = sd_we_reg;
    assign sd_d        = sd_d_reg;
    assign wr_overflow = wr_overflow_reg;

endmodule
